// File: rtl/sync_fifo_64to256_pkg.sv
// Shared constants and types for the 64-to-256 width-up FIFO.
// Defaults, the pack ratio, output-mode encodings and the level-update opcode.
package sync_fifo_64to256_pkg;

  localparam int PACK_RATIO  = 4;
  localparam int DEF_WIDTH_I = 64;
  localparam int DEF_WIDTH_O = 256;

  localparam int OUT_COMB = 0;
  localparam int OUT_REG  = 1;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_INC,
    LVL_DEC3,
    LVL_DEC4
  } lvl_op_e;

endpackage

// File: rtl/sync_fifo_64to256_if.sv
// Handshake bundle for the width-up FIFO: narrow write side, wide read side.
// Error flags exist only when SYNC_FIFO_64TO256_ERR_EN is defined.
interface sync_fifo_64to256_if
  import sync_fifo_64to256_pkg::*;
#(
  parameter int DATA_WIDTH_I = DEF_WIDTH_I,
  parameter int DATA_WIDTH_O = DEF_WIDTH_O,
  parameter int FIFO_DEPTH   = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                    fifo_wr;
  logic [DATA_WIDTH_I-1:0] fifo_din;
  logic                    fifo_full;
  logic                    fifo_rd;
  logic [DATA_WIDTH_O-1:0] fifo_dout;
  logic                    fifo_empty;
  logic [LW-1:0]           fifo_level;
`ifdef SYNC_FIFO_64TO256_ERR_EN
  logic                    fifo_ovf;
  logic                    fifo_udf;
`endif

  modport master (
    output fifo_wr, fifo_din, fifo_rd,
    input  fifo_full, fifo_dout, fifo_empty, fifo_level
`ifdef SYNC_FIFO_64TO256_ERR_EN
    , input fifo_ovf, fifo_udf
`endif
  );

  modport slave (
    input  fifo_wr, fifo_din, fifo_rd,
    output fifo_full, fifo_dout, fifo_empty, fifo_level
`ifdef SYNC_FIFO_64TO256_ERR_EN
    , output fifo_ovf, fifo_udf
`endif
  );

endinterface

// File: rtl/sync_fifo_64to256_ctrl.sv
// Pointer, level and flag control for the width-up FIFO.
// With SYNC_FIFO_64TO256_ERR_EN defined it also keeps sticky overflow/underflow flags.
module sync_fifo_64to256_ctrl
  import sync_fifo_64to256_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_wr,
  input  logic          fifo_rd,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
`ifdef SYNC_FIFO_64TO256_ERR_EN
  , output logic        ovf
  , output logic        udf
`endif
);

  lvl_op_e op;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level < LW'(PACK_RATIO));
  assign wr_en = fifo_wr & ~full;
  assign rd_en = fifo_rd & ~empty;

  always_comb begin
    op = LVL_HOLD;
    case ({wr_en, rd_en})
      2'b11:   op = LVL_DEC3;
      2'b10:   op = LVL_INC;
      2'b01:   op = LVL_DEC4;
      default: op = LVL_HOLD;
    endcase
  end

  // Pointers wrap naturally at FIFO_DEPTH; rd_ptr only ever moves by whole groups.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(PACK_RATIO);
      case (op)
        LVL_INC:  level <= level + LW'(1);
        LVL_DEC3: level <= level - LW'(PACK_RATIO - 1);
        LVL_DEC4: level <= level - LW'(PACK_RATIO);
        default:  level <= level;
      endcase
    end
  end

`ifdef SYNC_FIFO_64TO256_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (fifo_wr & full)  ovf <= 1'b1;
      if (fifo_rd & empty) udf <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sync_fifo_64to256.sv
// Width-up FIFO: packs four 64-bit writes into one 256-bit read word, oldest word in the LSBs.
// Define SYNC_FIFO_64TO256_ERR_EN to add sticky fifo_ovf/fifo_udf outputs.
module sync_fifo_64to256
  import sync_fifo_64to256_pkg::*;
#(
  parameter int DATA_WIDTH_I = DEF_WIDTH_I,
  parameter int DATA_WIDTH_O = DEF_WIDTH_O,
  parameter int FIFO_DEPTH   = 16,
  parameter int OUTPUT_MODE  = OUT_COMB
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_fifo_64to256_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic                    wr_en;
  logic                    rd_en;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level;
  logic                    full;
  logic                    empty;
  logic [DATA_WIDTH_I-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH_O-1:0] rd_word;
  logic [DATA_WIDTH_O-1:0] dout_q;

  sync_fifo_64to256_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .fifo_wr (bus.fifo_wr),
    .fifo_rd (bus.fifo_rd),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .level   (level),
    .full    (full),
    .empty   (empty)
`ifdef SYNC_FIFO_64TO256_ERR_EN
    , .ovf   (bus.fifo_ovf)
    , .udf   (bus.fifo_udf)
`endif
  );

  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.fifo_level = level;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= bus.fifo_din;
    end
  end

  // rd_ptr is group-aligned and the depth is a multiple of 4, so a group never straddles the wrap.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < PACK_RATIO; k++)
      rd_word[k*DATA_WIDTH_I +: DATA_WIDTH_I] = mem[rd_ptr + AW'(k)];
  end

  always_ff @(posedge clk) begin
    if (rst)        dout_q <= '0;
    else if (rd_en) dout_q <= rd_word;
  end

  assign bus.fifo_dout = (OUTPUT_MODE == OUT_REG) ? dout_q : rd_word;

endmodule
